// File: rtl/serial_wide_adder_ctrl.sv
// Byte-serial add/subtract of NBYTES-wide operands through one shared 8-bit
// ripple slice, with valid/ready handshakes on both sides.
module serial_wide_adder_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   in_a,
   input  logic [8*NBYTES-1:0]   in_b,
   input  logic                  in_sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_sum,
   output logic                  out_carry,
   output logic                  busy
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_r;
   logic [IW-1:0]          idx_r;
   logic                   carry_r;
   logic                   out_carry_r;
   logic                   in_ready_r;
   logic                   out_valid_r;
   logic                   busy_r;
   logic [NBYTES-1:0][7:0] a_r;
   logic [NBYTES-1:0][7:0] b_r;
   logic [NBYTES-1:0][7:0] sum_r;
   logic [8:0]             slice_s;

   // Shared 8-bit slice on the byte selected by idx_r; B is pre-inverted for subtract
   always_comb begin
      slice_s = {1'b0, a_r[idx_r]} + {1'b0, b_r[idx_r]} + {8'd0, carry_r};
   end

   // Control FSM with registered handshake/status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         idx_r       <= {IW{1'b0}};
         carry_r     <= 1'b0;
         a_r         <= {W{1'b0}};
         b_r         <= {W{1'b0}};
         sum_r       <= {W{1'b0}};
         out_carry_r <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  a_r        <= in_a;
                  b_r        <= in_sub ? ~in_b : in_b;
                  carry_r    <= in_sub;
                  idx_r      <= {IW{1'b0}};
                  state_r    <= ADD;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            ADD: begin
               sum_r[idx_r] <= slice_s[7:0];
               carry_r      <= slice_s[8];
               if (idx_r == IW'(NBYTES - 1)) begin
                  // idx_r stays at the top byte so it never exceeds NBYTES-1
                  out_carry_r <= slice_s[8];
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else begin
                  idx_r <= idx_r + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r     <= IDLE;
               idx_r       <= {IW{1'b0}};
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign out_sum   = sum_r;
   assign out_carry = out_carry_r;

endmodule

// File: tb/tb_serial_wide_adder_ctrl.sv
// Bench for serial_wide_adder_ctrl: directed cases plus random ops on a 4-byte
// and a 1-byte instance, checked against a plain-arithmetic reference model.
module tb_serial_wide_adder_ctrl;

   logic        clk;
   logic        rst_n;

   logic        in_valid_s, in_ready_s, in_sub_s, out_valid_s, out_ready_s;
   logic        out_carry_s, busy_s;
   logic [31:0] in_a_s, in_b_s, out_sum_s;

   logic        n1_in_valid_s, n1_in_ready_s, n1_in_sub_s, n1_out_valid_s;
   logic        n1_out_ready_s, n1_out_carry_s, n1_busy_s;
   logic [7:0]  n1_in_a_s, n1_in_b_s, n1_out_sum_s;

   int vectors;
   int miscompares;

   serial_wide_adder_ctrl #(.NBYTES(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_s), .in_ready(in_ready_s),
      .in_a(in_a_s), .in_b(in_b_s), .in_sub(in_sub_s),
      .out_valid(out_valid_s), .out_ready(out_ready_s),
      .out_sum(out_sum_s), .out_carry(out_carry_s), .busy(busy_s)
   );

   serial_wide_adder_ctrl #(.NBYTES(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(n1_in_valid_s), .in_ready(n1_in_ready_s),
      .in_a(n1_in_a_s), .in_b(n1_in_b_s), .in_sub(n1_in_sub_s),
      .out_valid(n1_out_valid_s), .out_ready(n1_out_ready_s),
      .out_sum(n1_out_sum_s), .out_carry(n1_out_carry_s), .busy(n1_busy_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // {carry,sum}: add is the wide sum; subtract carry means "no borrow", i.e. A >= B
   function automatic logic [32:0] ref4(input logic [31:0] a, input logic [31:0] b, input logic sub);
      if (sub) return {(a >= b), a - b};
      else     return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [8:0] ref1(input logic [7:0] a, input logic [7:0] b, input logic sub);
      if (sub) return {(a >= b), a - b};
      else     return {1'b0, a} + {1'b0, b};
   endfunction

   task automatic run_op4(input logic [31:0] a, input logic [31:0] b, input logic sub, input string tag);
      logic [32:0] e;
      int k, lat_v, lat_r;
      e = ref4(a, b, sub);
      in_a_s = a; in_b_s = b; in_sub_s = sub; in_valid_s = 1'b1;
      k = 0;
      while (!in_ready_s && k < 50) begin @(posedge clk); #1; k++; end
      check({tag, "_accept_wait"}, 64'(k < 50), 64'd1);
      @(posedge clk); #1;
      in_valid_s = 1'b0;
      in_a_s = $urandom; in_b_s = $urandom; in_sub_s = 1'($urandom);
      check({tag, "_busy"}, 64'(busy_s), 64'd1);
      lat_v = 0; lat_r = 0; k = 0;
      while (lat_r == 0 && k < 20) begin
         @(posedge clk); #1; k++;
         if (out_valid_s && lat_v == 0) begin
            lat_v = k;
            check({tag, "_sum"}, 64'(out_sum_s), 64'(e[31:0]));
            check({tag, "_carry"}, 64'(out_carry_s), 64'(e[32]));
         end
         if (in_ready_s) lat_r = k;
      end
      check({tag, "_out_latency"}, 64'(lat_v), 64'd4);
      check({tag, "_ready_low_cycles"}, 64'(lat_r), 64'd5);
   endtask

   task automatic run_op1(input logic [7:0] a, input logic [7:0] b, input logic sub, input string tag);
      logic [8:0] e;
      int k, lat_v, lat_r;
      e = ref1(a, b, sub);
      n1_in_a_s = a; n1_in_b_s = b; n1_in_sub_s = sub; n1_in_valid_s = 1'b1;
      k = 0;
      while (!n1_in_ready_s && k < 50) begin @(posedge clk); #1; k++; end
      check({tag, "_accept_wait"}, 64'(k < 50), 64'd1);
      @(posedge clk); #1;
      n1_in_valid_s = 1'b0;
      lat_v = 0; lat_r = 0; k = 0;
      while (lat_r == 0 && k < 20) begin
         @(posedge clk); #1; k++;
         if (n1_out_valid_s && lat_v == 0) begin
            lat_v = k;
            check({tag, "_sum"}, 64'(n1_out_sum_s), 64'(e[7:0]));
            check({tag, "_carry"}, 64'(n1_out_carry_s), 64'(e[8]));
         end
         if (n1_in_ready_s) lat_r = k;
      end
      check({tag, "_out_latency"}, 64'(lat_v), 64'd1);
      check({tag, "_ready_low_cycles"}, 64'(lat_r), 64'd2);
   endtask

   initial begin
      logic [32:0] e;
      int k, seen;
      vectors = 0; miscompares = 0;
      rst_n = 1'b0;
      in_valid_s = 1'b0; in_a_s = 32'd0; in_b_s = 32'd0; in_sub_s = 1'b0; out_ready_s = 1'b1;
      n1_in_valid_s = 1'b0; n1_in_a_s = 8'd0; n1_in_b_s = 8'd0; n1_in_sub_s = 1'b0;
      n1_out_ready_s = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      check("rst_in_ready", 64'(in_ready_s), 64'd1);
      check("rst_out_valid", 64'(out_valid_s), 64'd0);
      check("rst_busy", 64'(busy_s), 64'd0);
      check("rst_out_sum", 64'(out_sum_s), 64'd0);
      check("rst_out_carry", 64'(out_carry_s), 64'd0);
      check("rst_n1_in_ready", 64'(n1_in_ready_s), 64'd1);

      run_op4(32'h0000_00F5, 32'h0000_0003, 1'b0, "add_f5_3");
      run_op4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "add_full_carry");
      run_op4(32'h00FF_00FF, 32'h0001_0001, 1'b0, "add_split_carry");
      run_op4(32'd5, 32'd3, 1'b1, "sub_5_3");
      run_op4(32'd3, 32'd5, 1'b1, "sub_3_5");

      // Backpressure: result held in DONE while a new request waits
      out_ready_s = 1'b0;
      e = ref4(32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
      in_a_s = 32'h1234_5678; in_b_s = 32'h0F0F_0F0F; in_sub_s = 1'b0; in_valid_s = 1'b1;
      @(posedge clk); #1;
      in_valid_s = 1'b0;
      k = 0;
      while (!out_valid_s && k < 20) begin @(posedge clk); #1; k++; end
      check("bp_latency", 64'(k), 64'd4);
      in_a_s = 32'h1000_0000; in_b_s = 32'h0000_0001; in_sub_s = 1'b1; in_valid_s = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", 64'(out_valid_s), 64'd1);
         check("bp_hold_sum", 64'(out_sum_s), 64'(e[31:0]));
         check("bp_hold_carry", 64'(out_carry_s), 64'(e[32]));
         check("bp_hold_in_ready", 64'(in_ready_s), 64'd0);
      end
      out_ready_s = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", 64'(out_valid_s), 64'd0);
      check("bp_release_in_ready", 64'(in_ready_s), 64'd1);
      @(posedge clk); #1;
      in_valid_s = 1'b0;
      check("bp_pending_busy", 64'(busy_s), 64'd1);
      e = ref4(32'h1000_0000, 32'h0000_0001, 1'b1);
      k = 0;
      while (!out_valid_s && k < 20) begin @(posedge clk); #1; k++; end
      check("bp_pending_latency", 64'(k), 64'd4);
      check("bp_pending_sum", 64'(out_sum_s), 64'(e[31:0]));
      check("bp_pending_carry", 64'(out_carry_s), 64'(e[32]));
      @(posedge clk); #1;

      // Reset applied at the edge that would process byte 2
      in_a_s = 32'hAAAA_AAAA; in_b_s = 32'h5555_5555; in_sub_s = 1'b0; in_valid_s = 1'b1;
      k = 0;
      while (!in_ready_s && k < 20) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      in_valid_s = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_in_ready", 64'(in_ready_s), 64'd1);
      check("midrst_out_valid", 64'(out_valid_s), 64'd0);
      check("midrst_busy", 64'(busy_s), 64'd0);
      check("midrst_out_sum", 64'(out_sum_s), 64'd0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid_s) seen++;
      end
      check("midrst_no_valid_pulse", 64'(seen), 64'd0);
      run_op4(32'd7, 32'd9, 1'b0, "add_7_9_after_rst");

      run_op1(8'hFF, 8'h01, 1'b0, "n1_add_ff_1");
      run_op1(8'h03, 8'h05, 1'b1, "n1_sub_3_5");

      for (int i = 0; i < 40; i++) begin
         run_op4($urandom, $urandom, 1'($urandom), "rand4");
      end
      for (int i = 0; i < 20; i++) begin
         run_op1(8'($urandom), 8'($urandom), 1'($urandom), "rand1");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
